// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder
// Reads back the value shown on a multiplexed 8-digit seven-segment display.
// The scanned {an, seg} bus is sampled, each digit is debounced, and its glyph
// is mapped back to a hex nibble. One 32-bit word is built per full scan and
// handed out through a one-entry output buffer.
//
// Build option: define SEG_DEC_SYNC_EN to place a two-flop synchronizer on an/seg
// when the bus comes from another clock domain. This adds two cycles of input
// latency. Without it, an/seg feed the sample register directly.
//
// Handshake: frame_valid/frame_data/frame_dp/frame_err are held stable while
// frame_valid is high. A transfer happens on every rising edge where both
// frame_valid and frame_ready are high. A frame that completes while the buffer
// is occupied and not being drained is dropped, and overrun is set.
module seg_frame_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  an,
    input  logic [7:0]  seg,
    input  logic        frame_ready,
    input  logic        clr_overrun,
    output logic        frame_valid,
    output logic [31:0] frame_data,
    output logic [7:0]  frame_dp,
    output logic        frame_err,
    output logic        overrun,
    output logic        timeout
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] STABLE_PRE  = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);

    typedef enum logic {HUNT, COLLECT} state_t;

    logic [7:0]    an_in, seg_in;
    logic [7:0]    s_an, s_seg;
    logic [CW-1:0] stab_cnt;
    logic [7:0]    s_sel;
    logic          s_onehot, s_same;
    logic [2:0]    s_idx;
    logic [3:0]    s_nib;
    logic          s_err;
    logic          acc_vld, acc_dp, acc_err;
    logic [2:0]    acc_idx;
    logic [3:0]    acc_nib;
    state_t        state;
    logic [7:0]    seen, seen_upd;
    logic [TW-1:0] to_cnt;
    logic [31:0]   dig_nib, nib_upd;
    logic [7:0]    dig_dp, dp_upd, dig_err, err_upd;
    logic          frame_done, load_ok;

`ifdef SEG_DEC_SYNC_EN
    logic [7:0] an_meta, an_sync, seg_meta, seg_sync;

    // Two-flop synchronizer; idles at the blanked (all-ones) bus value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta  <= 8'hFF;
            an_sync  <= 8'hFF;
            seg_meta <= 8'hFF;
            seg_sync <= 8'hFF;
        end else begin
            an_meta  <= an;
            an_sync  <= an_meta;
            seg_meta <= seg;
            seg_sync <= seg_meta;
        end
    end

    assign an_in  = an_sync;
    assign seg_in = seg_sync;
`else
    assign an_in  = an;
    assign seg_in = seg;
`endif

    assign s_same   = ({an_in, seg_in} == {s_an, s_seg});
    assign s_sel    = ~s_an;
    assign s_onehot = (s_sel != 8'h00) && ((s_sel & (s_sel - 8'h01)) == 8'h00);

    // Sample register and saturating stability counter (restarts at 1 on change).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_an     <= 8'hFF;
            s_seg    <= 8'hFF;
            stab_cnt <= '0;
        end else begin
            s_an  <= an_in;
            s_seg <= seg_in;
            if (!s_same)
                stab_cnt <= CW'(1);
            else if (stab_cnt != STABLE_MAX)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Digit index and glyph-to-nibble decode of the sampled pair.
    always_comb begin
        s_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (s_sel[i]) s_idx = 3'(i);
        s_nib = 4'h0;
        s_err = 1'b0;
        case (s_seg[6:0])
            7'h40: s_nib = 4'h0;
            7'h79: s_nib = 4'h1;
            7'h24: s_nib = 4'h2;
            7'h30: s_nib = 4'h3;
            7'h19: s_nib = 4'h4;
            7'h12: s_nib = 4'h5;
            7'h02: s_nib = 4'h6;
            7'h78: s_nib = 4'h7;
            7'h00: s_nib = 4'h8;
            7'h10: s_nib = 4'h9;
            7'h08: s_nib = 4'hA;
            7'h03: s_nib = 4'hB;
            7'h46: s_nib = 4'hC;
            7'h21: s_nib = 4'hD;
            7'h06: s_nib = 4'hE;
            7'h0E: s_nib = 4'hF;
            default: begin
                s_nib = 4'h0;
                s_err = 1'b1;
            end
        endcase
    end

    // One-shot acceptance: fires on the edge where the counter reaches its limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_vld <= 1'b0;
            acc_idx <= 3'd0;
            acc_nib <= 4'h0;
            acc_dp  <= 1'b0;
            acc_err <= 1'b0;
        end else begin
            acc_vld <= s_same && (stab_cnt == STABLE_PRE) && s_onehot;
            acc_idx <= s_idx;
            acc_nib <= s_nib;
            acc_dp  <= ~s_seg[7];
            acc_err <= s_err;
        end
    end

    // Digit store contents as they would look after writing the accepted digit.
    always_comb begin
        nib_upd                     = dig_nib;
        nib_upd[{acc_idx, 2'b00} +: 4] = acc_nib;
        dp_upd                      = dig_dp;
        dp_upd[acc_idx]             = acc_dp;
        err_upd                     = dig_err;
        err_upd[acc_idx]            = acc_err;
        seen_upd                    = seen | (8'h01 << acc_idx);
        frame_done                  = (state == COLLECT) && acc_vld && (seen_upd == 8'hFF);
        load_ok                     = !frame_valid || frame_ready;
    end

    // Frame assembly FSM together with the one-entry output buffer and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            seen        <= 8'h00;
            to_cnt      <= '0;
            dig_nib     <= 32'h0;
            dig_dp      <= 8'h00;
            dig_err     <= 8'h00;
            frame_valid <= 1'b0;
            frame_data  <= 32'h0;
            frame_dp    <= 8'h00;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (clr_overrun)
                overrun <= 1'b0;
            if (frame_done) begin
                if (load_ok) begin
                    frame_valid <= 1'b1;
                    frame_data  <= nib_upd;
                    frame_dp    <= dp_upd;
                    frame_err   <= |err_upd;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            case (state)
                HUNT: begin
                    if (acc_vld && (acc_idx == 3'd0)) begin
                        dig_nib <= nib_upd;
                        dig_dp  <= dp_upd;
                        dig_err <= err_upd;
                        seen    <= 8'h01;
                        to_cnt  <= '0;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (acc_vld) begin
                        dig_nib <= nib_upd;
                        dig_dp  <= dp_upd;
                        dig_err <= err_upd;
                        seen    <= seen_upd;
                    end
                    if (frame_done) begin
                        seen  <= 8'h00;
                        state <= HUNT;
                    end else if (to_cnt == TIMEOUT_MAX) begin
                        timeout <= 1'b1;
                        seen    <= 8'h00;
                        state   <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule
